// File: rtl/adc_link_pkg.sv
// ---------------------------------------------------------------------------
// adc_link_pkg
// Shared types and widths for the ADC LVDS link bring-up sequencer.
//   state_e        : sequencer state encoding (also exported as debug output)
//   TIMER_W        : width of the per-state timer and run-length counters
//   RETRY_W        : width of the failed-attempt counter
//   adc_bits_legal : true for the deserialiser word widths the link supports
// ---------------------------------------------------------------------------
package adc_link_pkg;

  localparam int TIMER_W = 16;
  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESET    = 3'd1,
    ST_WAIT_BIT = 3'd2,
    ST_WAIT_FRM = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_FAIL     = 3'd5,
    ST_ERROR    = 3'd6
  } state_e;

  function automatic bit adc_bits_legal(input int bits);
    return (bits == 8) || (bits == 10) || (bits == 12) || (bits == 14);
  endfunction

endpackage

// File: rtl/adc_align_sequencer.sv
// ---------------------------------------------------------------------------
// adc_align_sequencer
// Link bring-up controller for one ADC LVDS port: holds the ISERDES and
// aligners in reset, waits for bit-clock alignment, supervises frame lock,
// mirrors frame-lane bitslips onto the data lanes, and watches the frame
// word once locked, re-running bring-up on loss of lock with bounded retries.
//
// Ports
//   CtrlClkDiv   in   word clock, the only clock of the block
//   CtrlRstN     in   synchronous active-low reset
//   MmcmLocked   in   clock generator locked
//   BitClkDone   in   bit-clock aligner finished
//   FrmBitslipIn in   bitslip pulse from the frame aligner
//   FrmAlignDone in   frame aligner match flag
//   FrmWord      in   recovered frame word (low AdcBits valid)
//   Restart      in   single-cycle request to redo bring-up
//   SerdesRst    out  reset to ISERDES / bit-clock / frame aligners
//   DataBitslip  out  per-lane bitslip to the data deserialisers
//   AlignDone    out  link locked, data valid
//   AlignError   out  retries exhausted
//   RetryCnt     out  failed attempts since last reset / Restart
//   StateOut     out  current state (debug)
// ---------------------------------------------------------------------------
module adc_align_sequencer
  import adc_link_pkg::*;
#(
  parameter int          AdcBits      = 14,
  parameter int          Lanes        = 2,
  parameter logic [15:0] FrmPattern   = 16'b0011111110000000,
  parameter int          RstCycles    = 16,
  parameter int          BitTimeout   = 4096,
  parameter int          FrmTimeout   = 512,
  parameter int          StableCycles = 8,
  parameter int          MissThresh   = 4,
  parameter int          MaxRetry     = 3
) (
  input  logic               CtrlClkDiv,
  input  logic               CtrlRstN,
  input  logic               MmcmLocked,
  input  logic               BitClkDone,
  input  logic               FrmBitslipIn,
  input  logic               FrmAlignDone,
  input  logic [15:0]        FrmWord,
  input  logic               Restart,
  output logic               SerdesRst,
  output logic [Lanes-1:0]   DataBitslip,
  output logic               AlignDone,
  output logic               AlignError,
  output logic [RETRY_W-1:0] RetryCnt,
  output logic [2:0]         StateOut
);

  generate
    if (!adc_bits_legal(AdcBits)) begin : g_bad_adc_bits
      $error("adc_align_sequencer: AdcBits must be 8, 10, 12 or 14");
    end
  endgenerate

  // Terminal counts: each counter is compared before it would increment,
  // so the "last" value is one below the configured length.
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RstCycles - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST    = TIMER_W'(BitTimeout - 1);
  localparam logic [TIMER_W-1:0] FRM_LAST    = TIMER_W'(FrmTimeout - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(StableCycles - 1);
  localparam logic [TIMER_W-1:0] MISS_LAST   = TIMER_W'(MissThresh - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   stable_q, stable_d;
  logic [TIMER_W-1:0]   miss_q, miss_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 reenter;
  logic                 frm_match;
  logic                 unused_frm_hi;

  assign frm_match     = (FrmWord[AdcBits-1:0] == FrmPattern[AdcBits-1:0]);
  assign unused_frm_hi = ^FrmWord[15:AdcBits];

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    stable_d = stable_q;
    miss_d   = miss_q;
    reenter  = 1'b0;
    timer_d  = timer_q;

    // Clock loss outranks everything but reset. In IDLE/ERROR it only
    // matters when it would otherwise let a Restart through.
    if (!MmcmLocked && (!(state_q inside {ST_IDLE, ST_ERROR}) || Restart)) begin
      state_d = ST_IDLE;
    end else if (Restart) begin
      state_d = ST_RESET;
      retry_d = '0;
      reenter = 1'b1;   // restart from RESET also restarts its hold time
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MmcmLocked) state_d = ST_RESET;
        end
        ST_RESET: begin
          if (timer_q == RST_LAST) state_d = ST_WAIT_BIT;
        end
        ST_WAIT_BIT: begin
          // Alignment arriving on the timeout cycle still counts.
          if (BitClkDone)               state_d = ST_WAIT_FRM;
          else if (timer_q == BIT_LAST) state_d = ST_FAIL;
        end
        ST_WAIT_FRM: begin
          if (!BitClkDone)                                state_d  = ST_FAIL;
          else if (FrmAlignDone && stable_q == STABLE_LAST) state_d = ST_LOCKED;
          else if (timer_q == FRM_LAST)                   state_d  = ST_FAIL;
          else if (FrmAlignDone)                          stable_d = stable_q + 1'b1;
          else                                            stable_d = '0;
        end
        ST_LOCKED: begin
          if (!BitClkDone)           state_d = ST_FAIL;
          else if (frm_match)        miss_d  = '0;
          else if (miss_q == MISS_LAST) state_d = ST_FAIL;
          else                       miss_d  = miss_q + 1'b1;
        end
        ST_FAIL: begin
          retry_d = (retry_q == {RETRY_W{1'b1}}) ? retry_q : retry_q + 1'b1;
          if ((int'(retry_q) + 1) > MaxRetry) state_d = ST_ERROR;
          else                                state_d = ST_RESET;
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // One timer shared by all states; every entry starts it from zero.
    if ((state_d != state_q) || reenter) begin
      timer_d  = '0;
      stable_d = '0;
      miss_d   = '0;
    end else if (timer_q != {TIMER_W{1'b1}}) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge CtrlClkDiv) begin
    if (!CtrlRstN) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      stable_q <= '0;
      miss_q   <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      miss_q   <= miss_d;
      retry_q  <= retry_d;
    end
  end

  // Status outputs decode the registered state, so AlignDone is high from
  // the first LOCKED cycle and drops the cycle the state leaves LOCKED.
  assign SerdesRst  = state_q inside {ST_IDLE, ST_RESET, ST_FAIL, ST_ERROR};
  assign AlignDone  = (state_q == ST_LOCKED);
  assign AlignError = (state_q == ST_ERROR);
  assign RetryCnt   = retry_q;
  assign StateOut   = state_q;

  // Data lanes slip in the same cycle as the frame lane, only while the
  // frame aligner is hunting.
  genvar gi;
  generate
    for (gi = 0; gi < Lanes; gi++) begin : g_lane_slip
      assign DataBitslip[gi] = (state_q == ST_WAIT_FRM) && FrmBitslipIn;
    end
  endgenerate

endmodule

// File: tb/tb_adc_align_sequencer.sv
module tb_adc_align_sequencer;

  localparam int          ADC_BITS   = 14;
  localparam int          LANES      = 2;
  localparam logic [15:0] PATTERN    = 16'b0011111110000000;
  localparam int          RST_CYC    = 16;
  localparam int          BIT_TO     = 4096;
  localparam int          FRM_TO     = 512;
  localparam int          STABLE     = 8;
  localparam int          MISS       = 4;
  localparam int          MAX_RETRY  = 3;
  localparam logic [15:0] GOOD_WORD  = 16'h3F80;
  localparam logic [15:0] WORD_MASK  = 16'h3FFF;

  logic        clk = 1'b0;
  logic        rst_n, mmcm, bit_done, frm_bs, frm_done, restart;
  logic [15:0] frm_word;
  logic        serdes_rst, align_done, align_err;
  logic [1:0]  data_bs;
  logic [3:0]  retry_cnt;
  logic [2:0]  state_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adc_align_sequencer #(
    .AdcBits(ADC_BITS), .Lanes(LANES), .FrmPattern(PATTERN),
    .RstCycles(RST_CYC), .BitTimeout(BIT_TO), .FrmTimeout(FRM_TO),
    .StableCycles(STABLE), .MissThresh(MISS), .MaxRetry(MAX_RETRY)
  ) dut (
    .CtrlClkDiv(clk), .CtrlRstN(rst_n), .MmcmLocked(mmcm),
    .BitClkDone(bit_done), .FrmBitslipIn(frm_bs), .FrmAlignDone(frm_done),
    .FrmWord(frm_word), .Restart(restart), .SerdesRst(serdes_rst),
    .DataBitslip(data_bs), .AlignDone(align_done), .AlignError(align_err),
    .RetryCnt(retry_cnt), .StateOut(state_out)
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // Tracks which phase of bring-up the link is in and how long it has been
  // there; lock and loss-of-lock are judged from the recent history of
  // samples kept in queues.
  int m_st = 0;
  int m_cyc = 0;
  int m_retry = 0;
  bit m_fq[$];
  bit m_bq[$];

  function automatic bit all_recent_ones(input bit q[$], input int n);
    if (q.size() < n) return 1'b0;
    for (int i = q.size() - n; i < q.size(); i++)
      if (!q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_enter(input int s);
    m_st = s;
    m_cyc = 0;
    m_fq.delete();
    m_bq.delete();
  endfunction

  function automatic void model_step();
    int nxt;
    bit again;
    nxt = m_st;
    again = 1'b0;
    if (!rst_n) begin
      m_retry = 0;
      m_enter(0);
      return;
    end
    if (!mmcm && ((m_st != 0 && m_st != 6) || restart)) nxt = 0;
    else if (restart) begin
      m_retry = 0;
      nxt = 1;
      again = 1'b1;
    end else begin
      case (m_st)
        0: if (mmcm) nxt = 1;
        1: if (m_cyc + 1 == RST_CYC) nxt = 2;
        2: if (bit_done) nxt = 3; else if (m_cyc + 1 == BIT_TO) nxt = 5;
        3: begin
          m_fq.push_back(frm_done);
          if (m_fq.size() > STABLE) void'(m_fq.pop_front());
          if (!bit_done) nxt = 5;
          else if (all_recent_ones(m_fq, STABLE)) nxt = 4;
          else if (m_cyc + 1 == FRM_TO) nxt = 5;
        end
        4: begin
          m_bq.push_back((frm_word & WORD_MASK) != (PATTERN & WORD_MASK));
          if (m_bq.size() > MISS) void'(m_bq.pop_front());
          if (!bit_done) nxt = 5;
          else if (all_recent_ones(m_bq, MISS)) nxt = 5;
        end
        5: begin
          m_retry = (m_retry + 1 > 15) ? 15 : m_retry + 1;
          nxt = (m_retry > MAX_RETRY) ? 6 : 1;
        end
        default: nxt = m_st;
      endcase
    end
    if (nxt != m_st || again) m_enter(nxt);
    else m_cyc++;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("state", state_out, m_st);
    chk("serdes_rst", serdes_rst, (m_st == 0 || m_st == 1 || m_st == 5 || m_st == 6) ? 1 : 0);
    chk("align_done", align_done, (m_st == 4) ? 1 : 0);
    chk("align_error", align_err, (m_st == 6) ? 1 : 0);
    chk("retry_cnt", retry_cnt, m_retry);
    chk("data_bitslip", data_bs, (m_st == 3 && frm_bs) ? 3 : 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mmcm = 1'b0; bit_done = 1'b0; frm_bs = 1'b0;
    frm_done = 1'b0; restart = 1'b0; frm_word = GOOD_WORD;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst_n, mmcm, bdone, fdone, bslip, restart;
    logic [15:0] word;
    int          reps;
    int          e_state;
    bit          e_serdes, e_done, e_err;
    int          e_dbs;
    int          e_retry;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int c, lock_c, n_rst, npulse, nout;
    int rq[$];
    int prev;

    //            rst mm bd fd bs rs word        reps st sr dn er dbs rty
    tbl[0]  = '{0, 0, 0, 0, 0, 0, GOOD_WORD,  2,   0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, GOOD_WORD,  1,   1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, GOOD_WORD,  15,  1, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, GOOD_WORD,  1,   2, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 0, 1, 0, GOOD_WORD,  1,   3, 0, 0, 0, 3, 0};
    tbl[5]  = '{1, 1, 1, 1, 1, 0, GOOD_WORD,  7,   3, 0, 0, 0, 3, 0};
    tbl[6]  = '{1, 1, 1, 1, 0, 0, GOOD_WORD,  1,   4, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 1, 1, 0, 16'h0000,   3,   4, 0, 1, 0, 0, 0};
    tbl[8]  = '{1, 1, 1, 1, 0, 0, 16'hFF80,   1,   4, 0, 1, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, 0, 0, 16'h0000,   4,   5, 1, 0, 0, 0, 0};
    tbl[10] = '{1, 1, 1, 1, 0, 0, GOOD_WORD,  1,   1, 1, 0, 0, 0, 1};
    tbl[11] = '{1, 1, 1, 1, 0, 1, GOOD_WORD,  1,   1, 1, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 1, 1, 0, 0, GOOD_WORD,  1,   0, 1, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 1, 1, 0, 0, GOOD_WORD,  1,   1, 1, 0, 0, 0, 0};

    rst_n = 1'b0; mmcm = 1'b0; bit_done = 1'b0; frm_bs = 1'b0;
    frm_done = 1'b0; restart = 1'b0; frm_word = GOOD_WORD;

    for (int v = 0; v < 14; v++) begin
      rst_n = tbl[v].rst_n; mmcm = tbl[v].mmcm; bit_done = tbl[v].bdone;
      frm_done = tbl[v].fdone; frm_bs = tbl[v].bslip; restart = tbl[v].restart;
      frm_word = tbl[v].word;
      for (int r = 0; r < tbl[v].reps; r++) tick();
      chk($sformatf("vec%0d_state", v), state_out, tbl[v].e_state);
      chk($sformatf("vec%0d_serdes", v), serdes_rst, tbl[v].e_serdes);
      chk($sformatf("vec%0d_done", v), align_done, tbl[v].e_done);
      chk($sformatf("vec%0d_err", v), align_err, tbl[v].e_err);
      chk($sformatf("vec%0d_dbs", v), data_bs, tbl[v].e_dbs);
      chk($sformatf("vec%0d_retry", v), retry_cnt, tbl[v].e_retry);
      $display("[TB] vec %0d state=%0d retry=%0d", v, state_out, retry_cnt);
    end
    restart = 1'b0;

    // Bring-up with BitClkDone at cycle 40, frame stable 30 cycles later.
    do_reset();
    mmcm = 1'b1; n_rst = 0; lock_c = 0; prev = 0;
    for (c = 1; c <= 200 && lock_c == 0; c++) begin
      if (c == 40) bit_done = 1'b1;
      frm_done = (prev != 0 && c >= prev + 30);
      tick();
      if (state_out == 1 && serdes_rst) n_rst++;
      if (state_out == 3 && prev == 0) prev = c;
      if (state_out == 4) lock_c = c;
    end
    chk("s1_serdes_rst_len", n_rst, RST_CYC);
    chk("s1_lock_cycle", lock_c, 77);
    chk("s1_align_done", align_done, 1);
    $display("[TB] seq1 bring-up locked at cycle %0d", lock_c);

    // Frame bitslip pulses every 5 cycles, mirrored only in WAIT_FRM.
    do_reset();
    mmcm = 1'b1; bit_done = 1'b1; npulse = 0; nout = 0;
    for (c = 1; c <= 80; c++) begin
      frm_bs = (c % 5 == 0);
      tick();
      if (state_out == 3 && data_bs == 2'b11) npulse++;
      if (state_out != 3 && data_bs != 2'b00) nout++;
    end
    frm_bs = 1'b0;
    chk("s2_mirrored_pulses", npulse, 13);
    chk("s2_pulses_outside", nout, 0);
    $display("[TB] seq2 mirrored %0d bitslip pulses", npulse);

    // Clock loss in WAIT_FRM, then full resequence.
    do_reset();
    mmcm = 1'b1; bit_done = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    mmcm = 1'b0; frm_bs = 1'b1;
    tick();
    chk("s5_idle_state", state_out, 0);
    chk("s5_idle_dbs", data_bs, 0);
    chk("s5_idle_done", align_done, 0);
    mmcm = 1'b1; frm_bs = 1'b0; frm_done = 1'b1; lock_c = 0;
    for (c = 1; c <= 100 && lock_c == 0; c++) begin
      tick();
      if (state_out == 4) lock_c = c;
    end
    chk("s5_relock_cycle", lock_c, 26);
    $display("[TB] seq5 relocked after clock loss in %0d cycles", lock_c);

    // BitClkDone never rises: retries run out into ERROR.
    do_reset();
    mmcm = 1'b1; prev = 0; lock_c = 0;
    for (c = 1; c <= 20000 && lock_c == 0; c++) begin
      tick();
      if (retry_cnt != prev) begin
        prev = retry_cnt;
        rq.push_back(prev);
      end
      if (state_out == 6) lock_c = c;
    end
    chk("s3_error_cycle", lock_c, 16453);
    chk("s3_retry_steps", rq.size(), 4);
    for (int i = 0; i < rq.size() && i < 4; i++)
      chk($sformatf("s3_retry_step%0d", i), rq[i], i + 1);
    chk("s3_align_error", align_err, 1);
    chk("s3_serdes_rst", serdes_rst, 1);
    $display("[TB] seq3 entered ERROR at cycle %0d retry=%0d", lock_c, retry_cnt);

    // Restart out of ERROR, lock, then reset while locked.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("s6_restart_state", state_out, 1);
    chk("s6_restart_retry", retry_cnt, 0);
    chk("s6_restart_err", align_err, 0);
    bit_done = 1'b1; frm_done = 1'b1; lock_c = 0;
    for (c = 1; c <= 100 && lock_c == 0; c++) begin
      tick();
      if (state_out == 4) lock_c = c;
    end
    chk("s6_locked", state_out, 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s6_rst_state", state_out, 0);
    chk("s6_rst_serdes", serdes_rst, 1);
    chk("s6_rst_done", align_done, 0);
    chk("s6_rst_retry", retry_cnt, 0);
    $display("[TB] seq6 restart and reset from LOCKED done");

    // Randomised traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      rst_n    = ($urandom_range(0, 999) != 0);
      mmcm     = ($urandom_range(0, 399) != 0);
      bit_done = ($urandom_range(0, 199) != 0);
      frm_done = ($urandom_range(0, 19) != 0);
      frm_bs   = ($urandom_range(0, 3) == 0);
      restart  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) frm_word = 16'($urandom);
      else frm_word = GOOD_WORD | (16'($urandom) & 16'hC000);
      tick();
    end
    $display("[TB] random phase done state=%0d retry=%0d", state_out, retry_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
